// File: rtl/regfile_psr_pkg.sv
// Shared constants for the register file / PSR slice: flag bit positions,
// branch condition codes and ALU opcodes.
package regfile_psr_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;
    localparam int NFLAGS = 5;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd8;

endpackage

// File: rtl/regfile_psr_cond_eval.sv
// Branch condition evaluation from the registered PSR.
module cond_eval
    import regfile_psr_pkg::*;
(
    input  logic [NFLAGS-1:0] psr,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    logic n, z, f, l, c;

    always_comb begin
        n = psr[FLAG_N];
        z = psr[FLAG_Z];
        f = psr[FLAG_F];
        l = psr[FLAG_L];
        c = psr[FLAG_C];
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = !z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = !c;
            COND_HI: cond_true = l;
            COND_LS: cond_true = !l;
            COND_GT: cond_true = n;
            COND_LE: cond_true = !n;
            COND_FS: cond_true = f;
            COND_FC: cond_true = !f;
            COND_LO: cond_true = !l && !z;
            COND_HS: cond_true = l || z;
            COND_LT: cond_true = !n && !z;
            COND_GE: cond_true = n || z;
            COND_UC: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_psr.sv
// Two-read/one-write register file with write-through bypass, plus a
// per-bit maskable processor status register and condition evaluation.
module regfile_psr
    import regfile_psr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     raddr_src,
    input  logic [AW-1:0]     raddr_dest,
    output logic [DATA_W-1:0] rdata_src,
    output logic [DATA_W-1:0] rdata_dest,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        flags_in,
    input  logic [4:0]        flags_we,
    output logic [4:0]        psr,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [4:0]        psr_q, psr_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    // Per-bit mux keeps an X on a masked-off flag from reaching the PSR.
    always_comb begin
        psr_d = psr_q;
        for (int i = 0; i < NFLAGS; i++) begin
            if (flags_we[i]) psr_d[i] = flags_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            psr_q <= '0;
        end else begin
            regs_q <= regs_d;
            psr_q  <= psr_d;
        end
    end

    always_comb begin
        rdata_src  = (we && raddr_src  == waddr) ? wdata : regs_q[raddr_src];
        rdata_dest = (we && raddr_dest == waddr) ? wdata : regs_q[raddr_dest];
    end

    assign psr = psr_q;

    cond_eval u_cond_eval (
        .psr       (psr_q),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_regfile_psr.sv
// Self-checking bench for regfile_psr: directed steps followed by random
// traffic checked against an array/flag-table reference model.
module tb_regfile_psr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  raddr_src, raddr_dest, waddr, cond;
    logic [15:0] rdata_src, rdata_dest, wdata;
    logic        we, cond_true;
    logic [4:0]  flags_in, flags_we, psr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [16];
    logic [4:0]  m_psr;

    always #5 clk = ~clk;

    regfile_psr dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raddr_src  (raddr_src),
        .raddr_dest (raddr_dest),
        .rdata_src  (rdata_src),
        .rdata_dest (rdata_dest),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .flags_in   (flags_in),
        .flags_we   (flags_we),
        .psr        (psr),
        .cond       (cond),
        .cond_true  (cond_true)
    );

    // Condition table: codes 0-9 are flag/inverted-flag pairs in the order
    // Z, C, L, N, F; codes 10-13 combine two flags; 14 always, 15 never.
    function automatic logic ref_cond(input logic [4:0] p, input int c);
        int    pair_bit [5] = '{3, 0, 1, 4, 2};
        logic  f;
        if (c < 10) begin
            f = p[pair_bit[c / 2]];
            return (c % 2 == 1) ? !f : f;
        end
        case (c)
            10: return !(p[1] | p[3]);
            11: return p[1] | p[3];
            12: return !(p[4] | p[3]);
            13: return p[4] | p[3];
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the model mirrors what the edge should commit.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_psr = '0;
        end else begin
            if (we) m_regs[waddr] = wdata;
            for (int i = 0; i < 5; i++) if (flags_we[i] === 1'b1) m_psr[i] = flags_in[i];
        end
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; flags_in = 0; flags_we = 0;
    endtask

    initial begin
        logic [4:0] fx;
        reset_n = 0; raddr_src = 0; raddr_dest = 0; cond = 0;
        idle();
        foreach (m_regs[i]) m_regs[i] = 16'hDEAD;
        m_psr = 5'h1F;
        tick(); tick();
        reset_n = 1;
        #1;

        // Reset state
        chk("rst_psr", psr, 5'd0);
        for (int a = 0; a < 16; a += 5) begin
            raddr_src = a[3:0]; raddr_dest = 4'(15 - a); #1;
            chk("rst_src", rdata_src, 16'h0);
            chk("rst_dest", rdata_dest, 16'h0);
        end
        for (int c = 0; c < 16; c++) begin
            cond = c[3:0]; #1;
            chk("rst_cond", cond_true, ref_cond(5'd0, c));
        end

        // Writes to r3 and r15, then read both back
        we = 1; waddr = 3; wdata = 16'h1234; tick();
        waddr = 15; wdata = 16'hFFFF; tick();
        idle(); raddr_src = 3; raddr_dest = 15; #1;
        chk("rd_r3", rdata_src, 16'h1234);
        chk("rd_r15", rdata_dest, 16'hFFFF);

        // Write-through bypass, then stored value
        we = 1; waddr = 5; wdata = 16'hA5A5; raddr_src = 5; raddr_dest = 5; #1;
        chk("byp_src", rdata_src, 16'hA5A5);
        chk("byp_same", rdata_dest, 16'hA5A5);
        tick(); idle(); #1;
        chk("r5_held", rdata_src, 16'hA5A5);

        // r0 is writable
        we = 1; waddr = 0; wdata = 16'h0BEE; tick(); idle(); raddr_src = 0; #1;
        chk("r0_write", rdata_src, 16'h0BEE);

        // Masked PSR update and derived conditions
        flags_in = 5'b11111; flags_we = 5'b01010; tick(); idle(); #1;
        chk("psr_mask", psr, 5'b01010);
        cond = 0;  #1; chk("c_eq", cond_true, 1'b1);
        cond = 4;  #1; chk("c_hi", cond_true, 1'b1);
        cond = 6;  #1; chk("c_gt", cond_true, 1'b0);
        cond = 12; #1; chk("c_lt", cond_true, 1'b0);
        cond = 13; #1; chk("c_ge", cond_true, 1'b1);

        // X on masked-off flag inputs must not reach the PSR
        fx = 5'b1x0x1;
        flags_in = fx; flags_we = 5'b10101;
        #1; chk("psr_no_bypass", psr, 5'b01010);
        @(posedge clk); #1;
        m_psr = 5'b11011;
        idle(); #1;
        chk("psr_x_mask", psr, 5'b11011);
        chk("psr_no_x", {31'd0, $isunknown(psr)}, 32'd0);

        // Reset wins over a write and a full flag update in the same cycle
        we = 1; waddr = 7; wdata = 16'h7777; flags_in = 5'b11111; flags_we = 5'b11111;
        reset_n = 0; tick(); reset_n = 1; idle(); raddr_src = 7; raddr_dest = 3; #1;
        chk("rst_r7", rdata_src, 16'h0);
        chk("rst_r3", rdata_dest, 16'h0);
        chk("rst_psr2", psr, 5'd0);

        // Full condition sweep over every PSR value
        for (int p = 0; p < 32; p++) begin
            flags_in = p[4:0]; flags_we = 5'b11111; tick(); idle();
            for (int c = 0; c < 16; c++) begin
                cond = c[3:0]; #1;
                chk("sweep", {p[7:0], 4'(c), 19'd0, cond_true}, {p[7:0], 4'(c), 19'd0, ref_cond(p[4:0], c)});
            end
        end

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset_n    = ($urandom_range(0, 29) != 0);
            we         = $urandom_range(0, 1);
            waddr      = 4'($urandom);
            wdata      = 16'($urandom);
            raddr_src  = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            raddr_dest = 4'($urandom);
            flags_in   = 5'($urandom);
            flags_we   = 5'($urandom);
            cond       = 4'($urandom);
            #1;
            chk("rnd_src", rdata_src, (we && raddr_src == waddr) ? wdata : m_regs[raddr_src]);
            chk("rnd_dest", rdata_dest, (we && raddr_dest == waddr) ? wdata : m_regs[raddr_dest]);
            chk("rnd_psr", psr, m_psr);
            chk("rnd_cond", cond_true, ref_cond(m_psr, int'(cond)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_psr.md
REGFILE_PSR -- requirements
Module: regfile_psr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 The block SHALL have parameter NREGS, default 16, register count; address width is log2(NREGS).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port raddr_src, input, 4, read address for the ALU Rsrc operand.
REQ-006 The block SHALL have port raddr_dest, input, 4, read address for the ALU Rdest operand.
REQ-007 The block SHALL have port rdata_src, output, 16, Rsrc operand data.
REQ-008 The block SHALL have port rdata_dest, output, 16, Rdest operand data.
REQ-009 The block SHALL have port we, input, 1, register write enable.
REQ-010 The block SHALL have port waddr, input, 4, write address.
REQ-011 The block SHALL have port wdata, input, 16, write data (ALU Out).
REQ-012 The block SHALL have port flags_in, input, 5, ALU flags {N,Z,F,L,C} in bits [4:0] as N=4, Z=3, F=2, L=1, C=0.
REQ-013 The block SHALL have port flags_we, input, 5, per-bit PSR update mask.
REQ-014 The block SHALL have port psr, output, 5, current PSR with the flags_in bit layout.
REQ-015 The block SHALL have port cond, input, 4, branch/jump condition code.
REQ-016 The block SHALL have port cond_true, output, 1, condition evaluation result.

Function
REQ-017 The block SHALL write wdata into register waddr on a rising clk edge when we=1 and reset_n=1.
REQ-018 The block SHALL drive both read ports combinationally, with no access latency.
REQ-019 A read address equal to waddr while we=1 SHALL return wdata (write-through bypass); simultaneous identical read addresses SHALL return identical data.
REQ-020 r0 SHALL be an ordinary writable register, with no hard-wired zero.
REQ-021 On each rising edge with reset_n=1, each PSR bit i SHALL load flags_in[i] when flags_we[i]=1 and otherwise hold its value.
REQ-022 An X on flags_in for any bit whose flags_we bit is 0 SHALL NOT alter the PSR.
REQ-023 The register write and the PSR update in the same cycle SHALL be independent and both take effect.
REQ-024 cond_true SHALL be combinational from the registered psr only, with no bypass from flags_in: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 NV 0.
REQ-025 The block SHALL have no internal state beyond the register array and the 5-bit PSR.

Reset
REQ-026 While reset_n=0 at a rising edge, all registers and the PSR SHALL clear to 0, overriding we and flags_we.
REQ-027 After reset, rdata_src=rdata_dest=0 for any address with we=0, psr=0, and cond_true=1 for cond in {1,3,5,7,9,10,12,14}.
REQ-028 Reset asserted mid-operation SHALL discard the write pending in that cycle.

Structure
REQ-029 The shared package SHALL hold the flag bit-index constants (C,L,F,Z,N), the 16 condition-code constants and the ALU opcode constants.
REQ-030 Condition evaluation SHALL be one sub-module, cond_eval (psr, cond -> cond_true); the storage SHALL remain in regfile_psr.

Verification
REQ-031 The bench SHALL apply reset, then write r3=16'h1234 and r15=16'hFFFF, then read src=3, dest=15 -> 16'h1234 and 16'hFFFF.
REQ-032 The bench SHALL apply we=1, waddr=5, wdata=16'hA5A5 with raddr_src=5 in the same cycle -> rdata_src=16'hA5A5 before the edge, and r5 holds it after.
REQ-033 The bench SHALL apply flags_in=5'b11111 with flags_we=5'b01010 from psr=0 -> psr=5'b01010; then cond=0 (EQ)->1, 4 (HI)->1, 6 (GT)->0, 12 (LT)->0, 13 (GE)->1.
REQ-034 The bench SHALL apply flags_in=5'b1x0x1 with flags_we=5'b10101 -> psr bits N,F,C take 1,0,1; bits Z,L unchanged and free of X.
REQ-035 The bench SHALL assert reset_n=0 in the same cycle as we=1 to r7 and flags_we=5'b11111 -> r7=0 and psr=0 afterwards.
REQ-036 The bench SHALL sweep all 16 cond values over all 32 psr values -> cond_true matches the table in REQ-024 exactly.
